// File: rtl/gfx_cmd_seq.sv
// Byte-serial graphics command sequencer: decodes point/line commands and streams
// Bresenham-generated pixels (one per cycle) under valid/ready backpressure.
module gfx_cmd_seq #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CB = (COORD_W + 7) / 8;
    localparam int unsigned NB = 4 * CB + 1;
    // One spare bit over the spec minimum keeps 2*e representable without special casing.
    localparam int unsigned SW = COORD_W + 3;
    localparam logic [3:0] LAST_P = 4'(2 * CB);
    localparam logic [3:0] LAST_L = 4'(4 * CB);

    typedef enum logic [1:0] {IDLE, OPER, SETUP, DRAW} state_t;

    state_t                   state;
    logic [8*NB-1:0]          ops;
    logic [3:0]               cnt;
    logic [3:0]               last;
    logic                     is_line;
    logic [COORD_W-1:0]       cur_x, cur_y, end_x, end_y;
    logic [COLOR_W-1:0]       color;
    logic signed [SW-1:0]     dx, dy, e;
    logic                     sx_pos, sy_pos;

    logic [COORD_W-1:0]       op_xs, op_ys, op_xe, op_ye;
    logic [COLOR_W-1:0]       op_col;
    logic signed [SW-1:0]     xs_s, ys_s, xe_s, ye_s, adx, ady;
    logic signed [SW-1:0]     e2, e_next, add_x, add_y;
    logic                     move_x, move_y, at_end;

    // Operand byte layout: xs, ys, [xe, ye,] colour, each coordinate CB bytes LSB first.
    assign op_xs  = ops[0 +: COORD_W];
    assign op_ys  = ops[8*CB +: COORD_W];
    assign op_xe  = is_line ? ops[16*CB +: COORD_W] : op_xs;
    assign op_ye  = is_line ? ops[24*CB +: COORD_W] : op_ys;
    assign op_col = is_line ? ops[32*CB +: COLOR_W] : ops[16*CB +: COLOR_W];

    always_comb begin
        xs_s = signed'(SW'(op_xs));
        ys_s = signed'(SW'(op_ys));
        xe_s = signed'(SW'(op_xe));
        ye_s = signed'(SW'(op_ye));
        adx  = (xe_s >= xs_s) ? xe_s - xs_s : xs_s - xe_s;
        ady  = (ye_s >= ys_s) ? ye_s - ys_s : ys_s - ye_s;
    end

    always_comb begin
        e2     = e <<< 1;
        move_x = (e2 >= dy);
        move_y = (e2 <= dx);
        add_x  = move_x ? dy : '0;
        add_y  = move_y ? dx : '0;
        e_next = e + add_x + add_y;
        at_end = (cur_x == end_x) && (cur_y == end_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ops       <= '0;
            cnt       <= '0;
            last      <= '0;
            is_line   <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            end_x     <= '0;
            end_y     <= '0;
            color     <= '0;
            dx        <= '0;
            dy        <= '0;
            e         <= '0;
            sx_pos    <= 1'b0;
            sy_pos    <= 1'b0;
            pix_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt <= '0;
                        if (cmd_data == 8'd80) begin
                            is_line <= 1'b0;
                            last    <= LAST_P;
                            state   <= OPER;
                        end else if (cmd_data == 8'd76) begin
                            is_line <= 1'b1;
                            last    <= LAST_L;
                            state   <= OPER;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                OPER: begin
                    if (cmd_valid) begin
                        for (int i = 0; i < int'(NB); i++) begin
                            if (cnt == 4'(i)) ops[8*i +: 8] <= cmd_data;
                        end
                        cnt <= cnt + 4'd1;
                        if (cnt == last) state <= SETUP;
                    end
                end
                SETUP: begin
                    cur_x     <= op_xs;
                    cur_y     <= op_ys;
                    end_x     <= op_xe;
                    end_y     <= op_ye;
                    color     <= op_col;
                    dx        <= adx;
                    dy        <= -ady;
                    e         <= adx - ady;
                    sx_pos    <= (op_xs < op_xe);
                    sy_pos    <= (op_ys < op_ye);
                    pix_valid <= 1'b1;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (pix_ready) begin
                        if (at_end) begin
                            pix_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            if (move_x) cur_x <= sx_pos ? cur_x + COORD_W'(1) : cur_x - COORD_W'(1);
                            if (move_y) cur_y <= sy_pos ? cur_y + COORD_W'(1) : cur_y - COORD_W'(1);
                            e <= e_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pix_x     = cur_x;
    assign pix_y     = cur_y;
    assign pix_color = color;
    assign busy      = (state != IDLE);
    assign cmd_ready = !rst && ((state == IDLE) || (state == OPER));

endmodule

// File: tb/tb_gfx_cmd_seq.sv
// Directed bench for gfx_cmd_seq: 8-bit and 10-bit coordinate instances, pixel scoreboards.
module tb_gfx_cmd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit coordinate instance
    logic       rst8, c8_v, c8_r, p8_valid, p8_ready, busy8, err8;
    logic [7:0] c8_d, p8_x, p8_y, p8_c;
    logic       rdy8_drv, bp8, bp_val;
    int         bpk = 0;
    assign p8_ready = bp8 ? bp_val : rdy8_drv;

    // 10-bit coordinate instance
    logic       rst10, c10_v, c10_r, p10_valid, p10_ready, busy10, err10;
    logic [7:0] c10_d, p10_c;
    logic [9:0] p10_x, p10_y;

    gfx_cmd_seq #(.COORD_W(8), .COLOR_W(8)) u8 (
        .clk(clk), .rst(rst8), .cmd_data(c8_d), .cmd_valid(c8_v), .cmd_ready(c8_r),
        .pix_x(p8_x), .pix_y(p8_y), .pix_color(p8_c), .pix_valid(p8_valid),
        .pix_ready(p8_ready), .busy(busy8), .err(err8)
    );

    gfx_cmd_seq #(.COORD_W(10), .COLOR_W(8)) u10 (
        .clk(clk), .rst(rst10), .cmd_data(c10_d), .cmd_valid(c10_v), .cmd_ready(c10_r),
        .pix_x(p10_x), .pix_y(p10_y), .pix_color(p10_c), .pix_valid(p10_valid),
        .pix_ready(p10_ready), .busy(busy10), .err(err10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [23:0] q8[$];
    logic [27:0] q10[$];
    logic [23:0] hold8;
    logic [27:0] hold10;
    bit          held8 = 0, held10 = 0;
    int          hs8 = 0, hs10 = 0;

    // Pixel monitors: sampled on the falling edge, handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst8) held8 = 0;
        else begin
            if (held8) chk("stall8", {p8_valid, p8_x, p8_y, p8_c}, {1'b1, hold8});
            if (p8_valid && p8_ready) begin
                hs8++;
                chk("pix8_expected", q8.size() > 0, 1);
                if (q8.size() > 0) chk("pix8", {p8_x, p8_y, p8_c}, q8.pop_front());
            end
            held8 = p8_valid && !p8_ready;
            hold8 = {p8_x, p8_y, p8_c};
        end
    end

    always @(negedge clk) begin
        if (rst10) held10 = 0;
        else begin
            if (held10) chk("stall10", {p10_valid, p10_x, p10_y, p10_c}, {1'b1, hold10});
            if (p10_valid && p10_ready) begin
                hs10++;
                chk("pix10_expected", q10.size() > 0, 1);
                if (q10.size() > 0) chk("pix10", {p10_x, p10_y, p10_c}, q10.pop_front());
            end
            held10 = p10_valid && !p10_ready;
            hold10 = {p10_x, p10_y, p10_c};
        end
    end

    // Backpressure pattern 1,0,0,1 repeating.
    always @(posedge clk) begin
        if (bp8) begin
            #1;
            bp_val = (bpk % 4 == 0) || (bpk % 4 == 3);
            bpk++;
        end
    end

    task automatic send8(input logic [7:0] b);
        int n = 0;
        c8_d = b;
        c8_v = 1'b1;
        do begin @(negedge clk); n++; end while (!c8_r && n < 200);
        chk("cmd8_accept", c8_r, 1);
        @(posedge clk); #1;
        c8_v = 1'b0;
    endtask

    task automatic send10(input logic [7:0] b);
        int n = 0;
        c10_d = b;
        c10_v = 1'b1;
        do begin @(negedge clk); n++; end while (!c10_r && n < 200);
        chk("cmd10_accept", c10_r, 1);
        @(posedge clk); #1;
        c10_v = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("idle8", busy8, 0);
    endtask

    task automatic wait_idle10();
        int n = 0;
        while (busy10 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("idle10", busy10, 0);
    endtask

    // Reference all-octant Bresenham producing the expected 8-bit pixel sequence.
    task automatic push_line8(input int xs, input int ys, input int xe, input int ye,
                              input int c);
        int dx = (xe > xs) ? xe - xs : xs - xe;
        int dy = (ye > ys) ? ys - ye : ye - ys;
        int sx = (xs < xe) ? 1 : -1;
        int sy = (ys < ye) ? 1 : -1;
        int e  = dx + dy;
        int x  = xs;
        int y  = ys;
        int e2;
        for (int k = 0; k < 1000; k++) begin
            q8.push_back({8'(x), 8'(y), 8'(c)});
            if (x == xe && y == ye) break;
            e2 = 2 * e;
            if (e2 >= dy) begin e += dy; x += sx; end
            if (e2 <= dx) begin e += dx; y += sy; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        int shx[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int shy[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

        rst8 = 1; rst10 = 1; c8_v = 0; c10_v = 0; c8_d = 0; c10_d = 0;
        rdy8_drv = 1; p10_ready = 1; bp8 = 0; bp_val = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst8_ctl", {c8_r, p8_valid, busy8, err8}, 0);
        chk("rst8_pix", {p8_x, p8_y, p8_c}, 0);
        chk("rst10_ctl", {c10_r, p10_valid, busy10, err10}, 0);
        chk("rst10_pix", {p10_x, p10_y, p10_c}, 0);
        rst8 = 0; rst10 = 0;
        @(posedge clk); #1;
        chk("idle_ready8", c8_r, 1);

        // Point with first-pixel latency
        q8.push_back({8'd3, 8'd4, 8'hAA});
        send8(8'd80); send8(8'd3); send8(8'd4); send8(8'hAA);
        chk("pt_setup_valid", p8_valid, 0);
        chk("pt_setup_busy", busy8, 1);
        chk("pt_setup_ready", c8_r, 0);
        @(posedge clk); #1;
        chk("pt_first_valid", p8_valid, 1);
        chk("pt_first_xy", {p8_x, p8_y}, {8'd3, 8'd4});
        wait_idle8();
        chk("pt_q", q8.size(), 0);

        // Shallow positive line, sustained one pixel per cycle
        for (int i = 0; i < 8; i++) q8.push_back({8'(shx[i]), 8'(shy[i]), 8'h11});
        send8(8'd76); send8(8'd0); send8(8'd0); send8(8'd7); send8(8'd3); send8(8'h11);
        n = 0;
        while (!p8_valid && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        while (p8_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("shallow_cycles", n, 8);
        chk("shallow_q", q8.size(), 0);
        chk("shallow_ready_after", c8_r, 1);

        // Steep negative line
        base = hs8;
        push_line8(5, 9, 3, 2, 8'h22);
        send8(8'd76); send8(8'd5); send8(8'd9); send8(8'd3); send8(8'd2); send8(8'h22);
        wait_idle8();
        chk("steep_hs", hs8 - base, 8);
        chk("steep_q", q8.size(), 0);

        // Backpressure on a horizontal line
        base = hs8;
        bpk = 0;
        bp8 = 1;
        push_line8(0, 0, 3, 0, 8'h44);
        send8(8'd76); send8(8'd0); send8(8'd0); send8(8'd3); send8(8'd0); send8(8'h44);
        wait_idle8();
        bp8 = 0;
        chk("bp_hs", hs8 - base, 4);
        chk("bp_q", q8.size(), 0);

        // Unknown opcode
        send8(8'h41);
        chk("err_pulse", err8, 1);
        chk("err_busy", busy8, 0);
        @(posedge clk); #1;
        chk("err_clear", err8, 0);
        chk("err_ready", c8_r, 1);

        // Long line aborted by reset after 10 pixels
        base = hs8;
        for (int i = 0; i < 10; i++) q8.push_back({8'(i), 8'd0, 8'h55});
        send8(8'd76); send8(8'd0); send8(8'd0); send8(8'd200); send8(8'd0); send8(8'h55);
        n = 0;
        while ((hs8 - base) < 10 && n < 200) begin @(posedge clk); #1; n++; end
        chk("abort_hs", hs8 - base, 10);
        rdy8_drv = 0;
        rst8 = 1;
        @(posedge clk); #1;
        chk("abort_valid", p8_valid, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_ready_in_rst", c8_r, 0);
        rst8 = 0;
        rdy8_drv = 1;
        #1;
        chk("abort_ready", c8_r, 1);
        chk("abort_q", q8.size(), 0);
        q8.push_back({8'd10, 8'd20, 8'h5A});
        send8(8'd80); send8(8'd10); send8(8'd20); send8(8'h5A);
        wait_idle8();
        chk("post_rst_pt_q", q8.size(), 0);

        // 10-bit coordinates, two bytes per coordinate
        q10.push_back({10'd500, 10'd0, 8'h33});
        q10.push_back({10'd501, 10'd1, 8'h33});
        q10.push_back({10'd502, 10'd2, 8'h33});
        send10(8'd76); send10(8'hF4); send10(8'h01); send10(8'h00); send10(8'h00);
        send10(8'hF6); send10(8'h01); send10(8'h02); send10(8'h00); send10(8'h33);
        wait_idle10();
        chk("w10_hs", hs10, 3);
        chk("w10_q", q10.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gfx_cmd_seq.md
Name: gfx_cmd_seq

Overview:
- Byte-serial graphics command sequencer, parametrised in coordinate and colour width.
- Accepts opcode and operand bytes over a valid/ready stream and decodes point ('P') and line ('L') commands.
- Runs all-octant Bresenham line generation internally.
- Emits one pixel (x, y, colour) per cycle on a valid/ready pixel stream to the downstream pixel writer. Emission honours backpressure.

Parameters:
- COORD_W, 8: coordinate width in bits, 1..16. Each coordinate operand is CB = ceil(COORD_W/8) bytes, LSB byte first; bits above COORD_W are ignored.
- COLOR_W, 8: colour width in bits, 1..8. Colour is one operand byte; the low COLOR_W bits are used.

Ports:
- clk  in  1  system clock, rising edge only.
- rst  in  1  synchronous, active-high reset.
- cmd_data  in  8  command/operand byte.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready.
- pix_x  out  COORD_W  pixel x.
- pix_y  out  COORD_W  pixel y.
- pix_color  out  COLOR_W  pixel colour.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  downstream accepts pixel.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset (synchronous, takes effect on the clk edge with rst high):
  - State goes to IDLE.
  - pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0, err=0.
  - cmd_ready=0 while rst is high.
  - All operand and Bresenham registers are cleared.
  - rst during OPER/SETUP/DRAW aborts the command; no further pixels are emitted.
- States: IDLE, OPER, SETUP, DRAW. cmd_ready=1 in IDLE and OPER only.
- IDLE, on byte accept:
  - 80 ('P'): operand count = 2*CB+1 (x, y, colour), go to OPER.
  - 76 ('L'): operand count = 4*CB+1 (xs, ys, xe, ye, colour), go to OPER.
  - Any other value: err=1 for one cycle, byte discarded, stay IDLE.
- OPER:
  - Each accepted byte is shifted into the current operand; the count decrements.
  - When the last byte is accepted, go to SETUP.
  - A point loads xs=xe=x and ys=ye=y.
- SETUP, one cycle:
  - dx = |xe-xs|, dy = -|ye-ys|.
  - sx = +1 if xs<xe else -1; sy = +1 if ys<ye else -1.
  - e = dx+dy; cur = (xs, ys).
  - All arithmetic is signed, COORD_W+2 bits; no overflow is possible at any COORD_W.
  - Go to DRAW.
- DRAW:
  - pix_valid=1 with pix_x/pix_y = cur and pix_color = latched colour.
  - Outputs stay stable while pix_valid && !pix_ready.
  - On handshake with cur==(xe,ye): pix_valid drops next cycle and the state returns to IDLE.
  - On handshake otherwise, update from e2 = 2*e:
    - if e2>=dy: e+=dy and x+=sx.
    - if e2<=dx: e+=dx and y+=sy.
    - Both updates apply in the same cycle when both conditions hold.
  - The next pixel is presented the following cycle, giving a sustained 1 pixel/cycle when pix_ready is held high.
- Latency and counts:
  - Last operand byte accepted at edge N → SETUP in cycle N+1 → first pix_valid in cycle N+2.
  - Pixel count = max(|xe-xs|, |ye-ys|) + 1. A degenerate line (start == end) emits exactly 1 pixel. A point emits 1 pixel.
  - cmd_ready returns high in the cycle after the final pixel handshake.
- Coordinates never wrap: the line endpoints bound every emitted pixel.
- cmd_valid bytes presented while cmd_ready=0 are not consumed; the upstream holds them.

Test Plan:
- Point: bytes 80, 3, 4, 0xAA, pix_ready=1 → exactly one pixel (3,4,0xAA), first pix_valid 2 cycles after the last byte; busy then falls.
- Shallow positive line: 76, 0,0, 7,3, 0x11 → 8 pixels in consecutive cycles: (0,0)(1,0)(2,1)(3,1)(4,2)(5,2)(6,3)(7,3).
- Steep negative line: 76, 5,9, 3,2, 0x22 → 8 pixels ending at (3,2); y decrements every pixel; x steps exactly twice.
- Backpressure: horizontal line 0,0→3,0 with pix_ready toggling 1,0,0,1,... → each pixel held stable while stalled; exactly 4 handshakes, no duplicates or skips.
- Unknown opcode plus reset: byte 0x41 → err pulses for 1 cycle and state stays IDLE. Then a line 0,0→200,0 with rst asserted after 10 pixels → pix_valid=0 the next cycle, cmd_ready=1 after rst drops, and the next 'P' command works normally.
- COORD_W=10: 76, 0xF4,0x01, 0,0, 0xF6,0x01, 2,0, 0x33 → line (500,0)→(502,2) emits (500,0)(501,1)(502,2).
